// File: rtl/mc_ramp_pwm_array.sv
// mc_ramp_pwm_array
//   N-channel motor-controller core. Each channel slews its current command
//   toward its desired command by at most STEP per ramp tick, and drives one
//   glitch-free PWM output whose duty is latched only at period boundaries.
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous reset, active high (priority over ESTOP)
//   ESTOP       emergency stop, level sensitive, active high
//   DESIRED_MC  packed desired commands, ch i = [i*CMD_W +: CMD_W]
//   CURRENT_MC  packed ramped commands (registered)
//   AT_TARGET   combinational CURRENT_MC[i] == DESIRED_MC[i]
//   RAMP_TICK   registered copy of the ramp strobe
//   PWM         registered PWM output per channel
module mc_ramp_pwm_array #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CMD_W    = 5,
    parameter int unsigned STEP     = 1,
    parameter int unsigned RAMP_DIV = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ESTOP,
    input  logic [NUM_CH*CMD_W-1:0] DESIRED_MC,
    output logic [NUM_CH*CMD_W-1:0] CURRENT_MC,
    output logic [NUM_CH-1:0]       AT_TARGET,
    output logic                    RAMP_TICK,
    output logic [NUM_CH-1:0]       PWM
);

    localparam int unsigned MAXV = (1 << CMD_W) - 1;
    localparam int unsigned RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(RAMP_DIV - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CMD_W-1:0] CNT_LAST = CMD_W'(MAXV - 1);
    localparam logic [CMD_W:0]   STEP_X   = (CMD_W + 1)'(STEP);

    logic [RD_W-1:0]               rd_q, rd_d;
    logic [PS_W-1:0]               ps_q, ps_d;
    logic [CMD_W-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0][CMD_W-1:0]  cur_q, cur_d;
    logic [NUM_CH-1:0][CMD_W-1:0]  duty_q, duty_d;
    logic [NUM_CH-1:0]             pwm_q, pwm_d;
    logic                          tick_q, tick_d;

    logic [NUM_CH-1:0][CMD_W-1:0]  des;
    logic                          ramp_stb;
    logic                          step_stb;
    logic                          period_start;

    // One bounded ramp step; widened by one bit so neither the difference
    // nor the sum can wrap.
    function automatic logic [CMD_W-1:0] ramp_step(input logic [CMD_W-1:0] cur,
                                                   input logic [CMD_W-1:0] tgt);
        logic [CMD_W:0] cx;
        logic [CMD_W:0] tx;
        logic [CMD_W:0] d;
        logic [CMD_W:0] s;
        logic [CMD_W:0] r;
        cx = {1'b0, cur};
        tx = {1'b0, tgt};
        r  = cx;
        if (cx < tx) begin
            d = tx - cx;
            s = (d < STEP_X) ? d : STEP_X;
            r = cx + s;
        end else if (cx > tx) begin
            d = cx - tx;
            s = (d < STEP_X) ? d : STEP_X;
            r = cx - s;
        end
        return r[CMD_W-1:0];
    endfunction

    assign des = DESIRED_MC;

    always_comb begin
        ramp_stb     = (rd_q == RD_LAST);
        step_stb     = (ps_q == PS_LAST);
        period_start = step_stb && (cnt_q == CNT_LAST);

        rd_d   = ramp_stb ? '0 : rd_q + 1'b1;
        ps_d   = step_stb ? '0 : ps_q + 1'b1;
        cnt_d  = cnt_q;
        if (step_stb) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        tick_d = ramp_stb;

        cur_d  = cur_q;
        duty_d = duty_q;
        pwm_d  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ramp_stb) begin
                cur_d[i] = ramp_step(cur_q[i], des[i]);
            end
            // Duty takes the pre-update command so a same-cycle ramp step
            // waits for the next period.
            if (period_start) begin
                duty_d[i] = cur_q[i];
            end
            pwm_d[i] = (cnt_q < duty_q[i]);
        end

        if (ESTOP) begin
            rd_d   = '0;
            ps_d   = '0;
            cnt_d  = '0;
            cur_d  = '0;
            duty_d = '0;
            pwm_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q   <= '0;
            ps_q   <= '0;
            cnt_q  <= '0;
            cur_q  <= '0;
            duty_q <= '0;
            pwm_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            ps_q   <= ps_d;
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        AT_TARGET = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            AT_TARGET[i] = (cur_q[i] == des[i]);
        end
    end

    assign CURRENT_MC = cur_q;
    assign RAMP_TICK  = tick_q;
    assign PWM        = pwm_q;

endmodule
